// File: rtl/rt_core_pkg.sv
// RT-Core shared types and constants.
// Imported by fetch, decode and later pipeline stages.
package rt_core_pkg;

    typedef logic [15:0] instr_t;
    typedef logic [15:0] pc_t;

    localparam instr_t NOP_INSTR        = 16'h0000;
    localparam pc_t    DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/rt_fetch_fifo.sv
// Synchronous prefetch FIFO for the fetch stage.
// Flush dominates push and pop; DEPTH must be a power of two.
module rt_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rt_fetch_unit.sv
// RT-Core instruction fetch stage: PC, request credits and stale-response
// dropping in front of a small prefetch FIFO feeding the IF/ID boundary.
module rt_fetch_unit
    import rt_core_pkg::*;
#(
    parameter pc_t RESET_PC = DEFAULT_RESET_PC,
    parameter int  DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [15:0]  imem_addr,
    input  logic         imem_rsp_valid,
    input  logic [15:0]  imem_rsp_data,
    input  logic         redirect_valid,
    input  logic [15:0]  redirect_pc,
    input  logic         stall,
    output logic         if_valid,
    output logic [15:0]  if_instr,
    output logic [15:0]  if_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $bits(fetch_entry_t);

    pc_t           pc_q, pc_d;
    pc_t           rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [EW-1:0] fifo_head;
    fetch_entry_t  head_entry, push_entry;

    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          req_fire, rsp_fire, rsp_keep;
    logic          fifo_push, fifo_pop;

    assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok = occupancy < (CW + 1)'(DEPTH);

    // Valid depends only on state, redirect and reset, never on ready.
    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_addr      = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
    assign rsp_keep = rsp_fire && (drop_q == '0) && !redirect_valid;

    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign fifo_push  = rsp_keep && !fifo_full;
    assign fifo_pop   = !fifo_empty && !stall && !redirect_valid;

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            rsp_pc_d   = redirect_pc;
            // Everything still outstanding belongs to the old path.
            inflight_d = inflight_q - CW'(rsp_fire);
            drop_d     = inflight_q - CW'(rsp_fire);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 16'd1;
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    rt_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign head_entry = fetch_entry_t'(fifo_head);

    assign if_valid = !fifo_empty;
    assign if_instr = if_valid ? head_entry.instr : NOP_INSTR;
    assign if_pc    = if_valid ? head_entry.pc : rsp_pc_q;

endmodule
